// File: rtl/stack_level_controller.sv
// Block-stacker level sequencer: walks the moving row, resolves drops against
// the row below, emits landed-row writes and tracks speed / win / lose.
module stack_level_controller #(
  parameter int         NUM_COLS   = 8,
  parameter int         NUM_ROWS   = 12,
  parameter int         INIT_WIDTH = 3,
  parameter logic [3:0] INIT_SPEED = 4'd10,
  parameter logic [3:0] SPEED_STEP = 4'd1,
  parameter logic [3:0] MIN_SPEED  = 4'd1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                drop,
  input  logic                tick,
  output logic                fc_enable,
  output logic                fc_reset_n,
  output logic [3:0]          speed_count,
  output logic [NUM_COLS-1:0] move_mask,
  output logic [3:0]          move_row,
  output logic                place_we,
  output logic [3:0]          place_row,
  output logic [NUM_COLS-1:0] place_mask,
  output logic                win,
  output logic                lose
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MOVE  = 3'd1;
  localparam logic [2:0] S_PLACE = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam logic [NUM_COLS-1:0] FULL_MASK = {NUM_COLS{1'b1}};
  localparam logic [NUM_COLS-1:0] INIT_MASK = FULL_MASK >> (NUM_COLS - INIT_WIDTH);
  localparam logic [3:0]          LAST_ROW  = 4'(NUM_ROWS - 1);

  logic [2:0]          state;
  logic                dir;        // 0: toward MSB (left), 1: toward LSB (right)
  logic                tick_q;
  logic [NUM_COLS-1:0] prev_mask;
  logic [NUM_COLS-1:0] land;
  logic [NUM_COLS-1:0] land_next;
  logic [NUM_COLS-1:0] step_mask;
  logic                step_dir;
  logic                tick_rise;

  // Lower the period by SPEED_STEP, clamped at MIN_SPEED; widened so a small
  // speed never wraps through zero.
  function automatic logic [3:0] speed_down(input logic [3:0] s);
    logic [4:0] floor_sum;
    floor_sum = {1'b0, MIN_SPEED} + {1'b0, SPEED_STEP};
    if ({1'b0, s} >= floor_sum) return s - SPEED_STEP;
    else                        return MIN_SPEED;
  endfunction

  assign fc_enable  = (state == S_MOVE);
  assign fc_reset_n = (state == S_MOVE);
  assign tick_rise  = tick & ~tick_q;
  assign land_next  = move_mask & prev_mask;

  // One-column step with bounce; a full-width block has nowhere to go.
  always_comb begin
    step_mask = move_mask;
    step_dir  = dir;
    if (move_mask != FULL_MASK) begin
      if (!dir) begin
        if (move_mask[NUM_COLS-1]) begin
          step_dir  = 1'b1;
          step_mask = move_mask >> 1;
        end else begin
          step_mask = move_mask << 1;
        end
      end else begin
        if (move_mask[0]) begin
          step_dir  = 1'b0;
          step_mask = move_mask << 1;
        end else begin
          step_mask = move_mask >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      dir         <= 1'b0;
      tick_q      <= 1'b0;
      prev_mask   <= FULL_MASK;
      land        <= '0;
      speed_count <= INIT_SPEED;
      move_mask   <= '0;
      move_row    <= '0;
      place_we    <= 1'b0;
      place_row   <= '0;
      place_mask  <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      tick_q <= tick;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state       <= S_MOVE;
            move_mask   <= INIT_MASK;
            move_row    <= '0;
            dir         <= 1'b0;
            prev_mask   <= FULL_MASK;
            speed_count <= INIT_SPEED;
            win         <= 1'b0;
            lose        <= 1'b0;
          end
        end
        S_MOVE: begin
          // Drop wins over a coincident tick so PLACE sees the pre-step mask.
          if (drop) begin
            state      <= S_PLACE;
            land       <= land_next;
            place_we   <= |land_next;
            place_row  <= move_row;
            place_mask <= land_next;
          end else if (tick_rise) begin
            move_mask <= step_mask;
            dir       <= step_dir;
          end
        end
        S_PLACE: begin
          place_we <= 1'b0;
          if (land == '0) begin
            state <= S_LOSE;
            lose  <= 1'b1;
          end else begin
            prev_mask <= land;
            if (move_row == LAST_ROW) begin
              state <= S_WIN;
              win   <= 1'b1;
            end else begin
              state       <= S_MOVE;
              move_row    <= move_row + 4'd1;
              move_mask   <= land;
              speed_count <= speed_down(speed_count);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_level_controller.sv
// Directed bench: a 3-wide game instance and a full-width (8-wide) instance.
module tb_stack_level_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic drop_a = 1'b0;
  logic drop_b = 1'b0;

  logic       a_fc_enable, a_fc_reset_n, a_place_we, a_win, a_lose;
  logic [3:0] a_speed_count, a_move_row, a_place_row;
  logic [7:0] a_move_mask, a_place_mask;
  logic       b_fc_enable, b_fc_reset_n, b_place_we, b_win, b_lose;
  logic [3:0] b_speed_count, b_move_row, b_place_row;
  logic [7:0] b_move_mask, b_place_mask;

  int n_cmp = 0;
  int n_bad = 0;
  int a_strobes = 0;
  int b_strobes = 0;

  always #5 clk = ~clk;

  stack_level_controller dut_a (
    .clk(clk), .reset(reset), .start(start), .drop(drop_a), .tick(tick),
    .fc_enable(a_fc_enable), .fc_reset_n(a_fc_reset_n), .speed_count(a_speed_count),
    .move_mask(a_move_mask), .move_row(a_move_row), .place_we(a_place_we),
    .place_row(a_place_row), .place_mask(a_place_mask), .win(a_win), .lose(a_lose)
  );

  stack_level_controller #(.INIT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .drop(drop_b), .tick(tick),
    .fc_enable(b_fc_enable), .fc_reset_n(b_fc_reset_n), .speed_count(b_speed_count),
    .move_mask(b_move_mask), .move_row(b_move_row), .place_we(b_place_we),
    .place_row(b_place_row), .place_mask(b_place_mask), .win(b_win), .lose(b_lose)
  );

  always @(negedge clk) begin
    if (a_place_we) a_strobes++;
    if (b_place_we) b_strobes++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({a_fc_enable, a_fc_reset_n, a_place_we, a_win, a_lose} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {a_fc_enable, a_fc_reset_n, a_place_we, a_win, a_lose});
    end
    n_cmp++;
    if ({a_move_mask, a_move_row, a_place_row, a_place_mask} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_masks: got %h want 000000",
               {a_move_mask, a_move_row, a_place_row, a_place_mask});
    end
    n_cmp++;
    if (a_speed_count !== 4'd10) begin
      n_bad++;
      $display("FAIL reset_speed: got %0d want 10", a_speed_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({a_move_mask, a_move_row, a_speed_count, a_fc_enable, a_fc_reset_n} !== {8'h07, 4'd0, 4'd10, 2'b11}) begin
      n_bad++;
      $display("FAIL start_init: mask %h row %0d speed %0d en %b rn %b want 07 0 10 1 1",
               a_move_mask, a_move_row, a_speed_count, a_fc_enable, a_fc_reset_n);
    end
  endtask

  task automatic test_walk();
    logic [7:0] exp_tab [7];
    exp_tab = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1;
      step();
      n_cmp++;
      if (a_move_mask !== exp_tab[i]) begin
        n_bad++;
        $display("FAIL walk_step%0d: got %h want %h", i, a_move_mask, exp_tab[i]);
      end
      tick = 1'b0;
      step();
    end
    // A held-high tick must not step again.
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    step();
    n_cmp++;
    if (a_move_mask !== 8'h1C) begin
      n_bad++;
      $display("FAIL walk_level: got %h want 1c", a_move_mask);
    end
  endtask

  task automatic test_drop_stack();
    int s0;
    restart();
    s0 = a_strobes;
    drop_a = 1'b1;
    step();
    drop_a = 1'b0;
    n_cmp++;
    if ({a_place_we, a_place_row, a_place_mask, a_fc_enable, a_fc_reset_n} !== {1'b1, 4'd0, 8'h07, 2'b00}) begin
      n_bad++;
      $display("FAIL drop0_place: we %b row %0d mask %h en %b rn %b want 1 0 07 0 0",
               a_place_we, a_place_row, a_place_mask, a_fc_enable, a_fc_reset_n);
    end
    step();
    n_cmp++;
    if ({a_place_we, a_move_row, a_move_mask, a_speed_count, a_fc_enable} !== {1'b0, 4'd1, 8'h07, 4'd9, 1'b1}) begin
      n_bad++;
      $display("FAIL drop0_next: we %b row %0d mask %h speed %0d en %b want 0 1 07 9 1",
               a_place_we, a_move_row, a_move_mask, a_speed_count, a_fc_enable);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    drop_a = 1'b1;
    step();
    drop_a = 1'b0;
    n_cmp++;
    if ({a_place_we, a_place_row, a_place_mask} !== {1'b1, 4'd1, 8'h06}) begin
      n_bad++;
      $display("FAIL drop1_place: we %b row %0d mask %h want 1 1 06", a_place_we, a_place_row, a_place_mask);
    end
    step();
    n_cmp++;
    if ({a_move_row, a_move_mask, a_speed_count} !== {4'd2, 8'h06, 4'd8}) begin
      n_bad++;
      $display("FAIL drop1_next: row %0d mask %h speed %0d want 2 06 8", a_move_row, a_move_mask, a_speed_count);
    end
    n_cmp++;
    if (a_strobes - s0 !== 2) begin
      n_bad++;
      $display("FAIL drop_strobes: got %0d want 2", a_strobes - s0);
    end
  endtask

  task automatic test_lose();
    int s0;
    restart();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    drop_a = 1'b1;
    step();
    drop_a = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    s0 = a_strobes;
    drop_a = 1'b1;
    step();
    drop_a = 1'b0;
    n_cmp++;
    if (a_place_we !== 1'b0) begin
      n_bad++;
      $display("FAIL lose_we: got %b want 0", a_place_we);
    end
    step();
    n_cmp++;
    if ({a_lose, a_win, a_fc_enable, a_move_mask} !== {3'b100, 8'h70}) begin
      n_bad++;
      $display("FAIL lose_state: lose %b win %b en %b mask %h want 1 0 0 70",
               a_lose, a_win, a_fc_enable, a_move_mask);
    end
    n_cmp++;
    if (a_strobes !== s0) begin
      n_bad++;
      $display("FAIL lose_strobes: got %0d want %0d", a_strobes, s0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({a_lose, a_move_mask, a_move_row, a_speed_count, a_fc_enable} !== {1'b0, 8'h07, 4'd0, 4'd10, 1'b1}) begin
      n_bad++;
      $display("FAIL lose_restart: lose %b mask %h row %0d speed %0d en %b want 0 07 0 10 1",
               a_lose, a_move_mask, a_move_row, a_speed_count, a_fc_enable);
    end
  endtask

  task automatic test_full_width_win();
    int s0;
    int bad_place;
    int exp_speed;
    restart();
    s0 = b_strobes;
    bad_place = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++;
        if (b_move_mask !== 8'hFF) begin
          n_bad++;
          $display("FAIL full_no_move: got %h want ff", b_move_mask);
        end
        step();
      end
      drop_b = 1'b1;
      step();
      drop_b = 1'b0;
      if ({b_place_we, b_place_row, b_place_mask} !== {1'b1, 4'(i), 8'hFF}) bad_place++;
      step();
      if (i < 11) begin
        exp_speed = (10 - (i + 1) < 1) ? 1 : 10 - (i + 1);
        n_cmp++;
        if (b_speed_count !== 4'(exp_speed)) begin
          n_bad++;
          $display("FAIL full_speed_row%0d: got %0d want %0d", i, b_speed_count, exp_speed);
        end
      end
    end
    n_cmp++;
    if (bad_place !== 0) begin
      n_bad++;
      $display("FAIL full_place: got %0d bad strobes want 0", bad_place);
    end
    n_cmp++;
    if (b_strobes - s0 !== 12) begin
      n_bad++;
      $display("FAIL full_strobes: got %0d want 12", b_strobes - s0);
    end
    n_cmp++;
    if ({b_win, b_lose, b_fc_enable, b_speed_count} !== {3'b100, 4'd1}) begin
      n_bad++;
      $display("FAIL full_win: win %b lose %b en %b speed %0d want 1 0 0 1",
               b_win, b_lose, b_fc_enable, b_speed_count);
    end
  endtask

  task automatic test_back_to_back();
    restart();
    tick = 1'b1;
    drop_a = 1'b1;
    step();
    tick = 1'b0;
    drop_a = 1'b0;
    n_cmp++;
    if ({a_place_we, a_place_mask, a_move_mask} !== {1'b1, 8'h07, 8'h07}) begin
      n_bad++;
      $display("FAIL coincide_place: we %b pmask %h mmask %h want 1 07 07", a_place_we, a_place_mask, a_move_mask);
    end
    step();
    n_cmp++;
    if ({a_move_row, a_move_mask} !== {4'd1, 8'h07}) begin
      n_bad++;
      $display("FAIL coincide_next: row %0d mask %h want 1 07", a_move_row, a_move_mask);
    end
  endtask

  task automatic test_reset_in_place();
    int s0;
    restart();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    drop_a = 1'b1;
    step();
    drop_a = 1'b0;
    reset = 1'b1;
    step();
    n_cmp++;
    if ({a_place_we, a_fc_enable, a_fc_reset_n, a_win, a_lose, a_move_mask, a_move_row, a_place_mask, a_speed_count}
        !== {5'b0, 8'h00, 4'd0, 8'h00, 4'd10}) begin
      n_bad++;
      $display("FAIL place_reset: we %b en %b mask %h row %0d pmask %h speed %0d want 0 0 00 0 00 10",
               a_place_we, a_fc_enable, a_move_mask, a_move_row, a_place_mask, a_speed_count);
    end
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    s0 = a_strobes;
    drop_a = 1'b1;
    reset = 1'b1;
    step();
    drop_a = 1'b0;
    reset = 1'b0;
    step();
    n_cmp++;
    if ({a_place_we, a_move_mask} !== {1'b0, 8'h00} || a_strobes !== s0) begin
      n_bad++;
      $display("FAIL drop_reset: we %b mask %h strobes %0d want 0 00 %0d", a_place_we, a_move_mask, a_strobes, s0);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_walk();
    test_drop_stack();
    test_lose();
    test_full_width_win();
    test_back_to_back();
    test_reset_in_place();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
